// File: rtl/rgb2bayer_mosaic.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2bayer_mosaic
//  Description : Re-mosaics an RGB888 pixel stream into a single 8-bit Bayer
//                raw stream (one colour sample per pixel), or emits luma-like
//                gray when mosaicing is disabled. Pixel phase is derived from
//                line/pixel counters that follow the demosaic rules, so a
//                RGB -> mosaic -> demosaic loop-back lines up directly.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEFAULT_PATTERN : pattern after reset (0=GRBG, 1=RGGB, 2=BGGR, 3=GBRG)
//    CNT_W           : width of the pixel (hcnt) and line (vcnt) counters
//  Ports
//    clk, rst_n                 : pixel clock, asynchronous active-low reset
//    mosaic_en                  : 1=Bayer output, 0=gray bypass (per frame)
//    cfg_pattern[1:0]           : requested Bayer pattern (per frame)
//    per_img_vsync/href/de      : input frame / line / pixel valid
//    per_img_red/green/blue     : input RGB888 pixel
//    post_img_vsync/href/de     : input timing delayed by 2 clocks
//    post_img_raw[7:0]          : Bayer sample or gray
//    post_img_phase[1:0]        : {row[0], col[0]} of the emitted pixel
// ============================================================================
module rgb2bayer_mosaic #(
  parameter logic [1:0] DEFAULT_PATTERN = 2'd0,
  parameter int         CNT_W           = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mosaic_en,
  input  logic [1:0] cfg_pattern,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic       per_img_de,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic       post_img_de,
  output logic [7:0] post_img_raw,
  output logic [1:0] post_img_phase
);

  // Pattern encodings
  localparam logic [1:0] c_PAT_GRBG = 2'd0;
  localparam logic [1:0] c_PAT_RGGB = 2'd1;
  localparam logic [1:0] c_PAT_BGGR = 2'd2;
  localparam logic [1:0] c_PAT_GBRG = 2'd3;

  // Channel selector encodings
  localparam logic [1:0] c_SEL_R = 2'd0;
  localparam logic [1:0] c_SEL_G = 2'd1;
  localparam logic [1:0] c_SEL_B = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Channel selection for a 2x2 Bayer cell; ph = {row[0], col[0]}
  // --------------------------------------------------------------------------
  function automatic logic [1:0] chan_sel(input logic [1:0] pattern,
                                          input logic [1:0] ph);
    logic [1:0] sel;
    sel = c_SEL_G;
    case (pattern)
      c_PAT_GRBG: begin
        case (ph)
          2'b01:   sel = c_SEL_R;
          2'b10:   sel = c_SEL_B;
          default: sel = c_SEL_G;
        endcase
      end
      c_PAT_RGGB: begin
        case (ph)
          2'b00:   sel = c_SEL_R;
          2'b11:   sel = c_SEL_B;
          default: sel = c_SEL_G;
        endcase
      end
      c_PAT_BGGR: begin
        case (ph)
          2'b00:   sel = c_SEL_B;
          2'b11:   sel = c_SEL_R;
          default: sel = c_SEL_G;
        endcase
      end
      c_PAT_GBRG: begin
        case (ph)
          2'b01:   sel = c_SEL_B;
          2'b10:   sel = c_SEL_R;
          default: sel = c_SEL_G;
        endcase
      end
      default: sel = c_SEL_G;
    endcase
    return sel;
  endfunction

  // --------------------------------------------------------------------------
  // Edge detection and counters
  // --------------------------------------------------------------------------
  logic             r_vs_dly;
  logic             r_de_dly;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [1:0]       r_active_pattern;
  logic             r_active_en;

  logic w_vs_rise;
  logic w_de_fall;

  assign w_vs_rise = ~r_vs_dly & per_img_vsync;
  assign w_de_fall = r_de_dly & ~per_img_de;

  // r_vs_dly resets high: if vsync is already asserted when reset releases,
  // that frame must not be mistaken for a fresh rising edge, so the reset
  // pattern/enable stay in force until a genuine frame start is observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_dly <= 1'b1;
      r_de_dly <= 1'b0;
    end else begin
      r_vs_dly <= per_img_vsync;
      r_de_dly <= per_img_de;
    end
  end

  // Pixel counter restarts on every de gap, so each de burst is a new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
    end else if (per_img_de) begin
      r_hcnt <= r_hcnt + c_CNT_ONE;
    end else begin
      r_hcnt <= '0;
    end
  end

  // Line counter advances at the end of every de burst inside the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt <= '0;
    end else if (!per_img_vsync) begin
      r_vcnt <= '0;
    end else if (w_de_fall) begin
      r_vcnt <= r_vcnt + c_CNT_ONE;
    end
  end

  // Frame-boundary latch of the runtime configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_pattern <= DEFAULT_PATTERN;
      r_active_en      <= 1'b0;
    end else if (w_vs_rise) begin
      r_active_pattern <= cfg_pattern;
      r_active_en      <= mosaic_en;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: capture colour, phase and gray
  // --------------------------------------------------------------------------
  logic [9:0] w_gray_sum;
  logic [7:0] r_s1_red;
  logic [7:0] r_s1_green;
  logic [7:0] r_s1_blue;
  logic [7:0] r_s1_gray;
  logic [1:0] r_s1_ph;

  // R + 2G + B peaks at 1020, which fits 10 bits; >>2 keeps it within 8 bits.
  assign w_gray_sum = {2'b00, per_img_red}
                    + {1'b0, per_img_green, 1'b0}
                    + {2'b00, per_img_blue};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_red   <= '0;
      r_s1_green <= '0;
      r_s1_blue  <= '0;
      r_s1_gray  <= '0;
      r_s1_ph    <= '0;
    end else begin
      r_s1_red   <= per_img_red;
      r_s1_green <= per_img_green;
      r_s1_blue  <= per_img_blue;
      r_s1_gray  <= w_gray_sum[9:2];
      r_s1_ph    <= {r_vcnt[0], r_hcnt[0]};
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: channel select / gray bypass, registered outputs
  // --------------------------------------------------------------------------
  logic [7:0] r_raw;
  logic [1:0] r_phase;
  logic [1:0] w_sel;

  assign w_sel = chan_sel(r_active_pattern, r_s1_ph);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw   <= '0;
      r_phase <= '0;
    end else begin
      r_phase <= r_s1_ph;
      if (!r_active_en) begin
        r_raw <= r_s1_gray;
      end else begin
        case (w_sel)
          c_SEL_R: r_raw <= r_s1_red;
          c_SEL_B: r_raw <= r_s1_blue;
          default: r_raw <= r_s1_green;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Timing signals: 2-deep shift register matching the data latency
  // --------------------------------------------------------------------------
  logic [1:0] r_vs_pipe;
  logic [1:0] r_href_pipe;
  logic [1:0] r_de_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_pipe   <= '0;
      r_href_pipe <= '0;
      r_de_pipe   <= '0;
    end else begin
      r_vs_pipe   <= {r_vs_pipe[0],   per_img_vsync};
      r_href_pipe <= {r_href_pipe[0], per_img_href};
      r_de_pipe   <= {r_de_pipe[0],   per_img_de};
    end
  end

  assign post_img_vsync = r_vs_pipe[1];
  assign post_img_href  = r_href_pipe[1];
  assign post_img_de    = r_de_pipe[1];
  assign post_img_raw   = r_raw;
  assign post_img_phase = r_phase;

  // Only the counter LSBs and the top gray bits carry information downstream.
  logic w_unused;
  assign w_unused = ^{r_hcnt[CNT_W-1:1], r_vcnt[CNT_W-1:1], w_gray_sum[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_rgb2bayer_mosaic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb2bayer_mosaic
//  Description : Scoreboard testbench for rgb2bayer_mosaic. Stimulus tasks
//                push hand-computed expected samples (value, phase, timing,
//                arrival cycle) into a queue; an independent monitor pops
//                and compares whenever post_img_de is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2bayer_mosaic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mosaic_en;
  logic [1:0] cfg_pattern;
  logic       per_img_vsync;
  logic       per_img_href;
  logic       per_img_de;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;
  logic       post_img_vsync;
  logic       post_img_href;
  logic       post_img_de;
  logic [7:0] post_img_raw;
  logic [1:0] post_img_phase;

  always #5 clk = ~clk;

  rgb2bayer_mosaic #(
    .DEFAULT_PATTERN(2'd0),
    .CNT_W          (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mosaic_en     (mosaic_en),
    .cfg_pattern   (cfg_pattern),
    .per_img_vsync (per_img_vsync),
    .per_img_href  (per_img_href),
    .per_img_de    (per_img_de),
    .per_img_red   (per_img_red),
    .per_img_green (per_img_green),
    .per_img_blue  (per_img_blue),
    .post_img_vsync(post_img_vsync),
    .post_img_href (post_img_href),
    .post_img_de   (post_img_de),
    .post_img_raw  (post_img_raw),
    .post_img_phase(post_img_phase)
  );

  typedef struct packed {
    logic        vs;
    logic        href;
    logic [1:0]  ph;
    logic [7:0]  raw;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cyc = 0;
  logic        cap_en = 1'b0;
  logic [7:0]  cap[16];
  int          cap_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pixel must match the queue head and arrive 2 clk
  // after it was driven.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && post_img_de === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_pixel: got raw=%0d ph=%0d, required no output",
                 post_img_raw, post_img_phase);
      end else begin
        e = q.pop_front();
        if ({post_img_vsync, post_img_href, post_img_phase, post_img_raw}
              !== {e.vs, e.href, e.ph, e.raw} || cyc != e.cyc + 2) begin
          n_err++;
          $display("FAIL pixel: got vs=%0b href=%0b ph=%0d raw=%0d cyc=%0d, required vs=%0b href=%0b ph=%0d raw=%0d cyc=%0d",
                   post_img_vsync, post_img_href, post_img_phase, post_img_raw, cyc,
                   e.vs, e.href, e.ph, e.raw, e.cyc + 2);
        end
        if (cap_en && cap_n < 16) begin
          cap[cap_n] = post_img_raw;
          cap_n++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One clock of input; a valid pixel also records its expected output.
  task automatic pix(input logic v, input logic h, input logic d,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [1:0] ph, input logic [7:0] ex);
    @(posedge clk);
    #1;
    per_img_vsync = v;
    per_img_href  = h;
    per_img_de    = d;
    per_img_red   = r;
    per_img_green = g;
    per_img_blue  = b;
    if (d) q.push_back('{v, h, ph, ex, cyc});
  endtask

  task automatic idle(input logic v, input int n);
    repeat (n) pix(v, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'b00, 8'd0);
  endtask

  // One line of n (<=4) pixels of constant colour; exp4 = {e0,e1,e2,e3}.
  task automatic line(input logic row, input int n,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [31:0] exp4);
    for (int c = 0; c < n; c++)
      pix(1'b1, 1'b1, 1'b1, r, g, b, {row, c[0]}, exp4[31-8*c -: 8]);
    idle(1'b1, 1);
  endtask

  // GRBG site colour: 0=R, 1=G, 2=B
  function automatic int grbg_chan(input int r, input int c);
    case ({r[0], c[0]})
      2'b01:   return 0;
      2'b10:   return 2;
      default: return 1;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    int cnt;
    int req;
    rst_n = 1'b0;
    mosaic_en = 1'b1;
    cfg_pattern = 2'd0;
    per_img_vsync = 1'b0;
    per_img_href = 1'b0;
    per_img_de = 1'b0;
    per_img_red = 8'd0;
    per_img_green = 8'd0;
    per_img_blue = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({post_img_vsync, post_img_href, post_img_de, post_img_raw, post_img_phase}), 0);
    rst_n = 1'b1;
    idle(1'b0, 2);

    // Frame A: GRBG, constant R=10 G=20 B=30
    idle(1'b1, 1);
    line(1'b0, 4, 8'd10, 8'd20, 8'd30, {8'd20, 8'd10, 8'd20, 8'd10});
    line(1'b1, 4, 8'd10, 8'd20, 8'd30, {8'd30, 8'd20, 8'd30, 8'd20});
    idle(1'b0, 3);

    // Frame B: RGGB; request BGGR mid-frame (no effect yet)
    cfg_pattern = 2'd1;
    idle(1'b1, 1);
    line(1'b0, 4, 8'd10, 8'd20, 8'd30, {8'd10, 8'd20, 8'd10, 8'd20});
    cfg_pattern = 2'd2;
    line(1'b1, 4, 8'd10, 8'd20, 8'd30, {8'd20, 8'd30, 8'd20, 8'd30});
    idle(1'b0, 3);

    // Frame C: BGGR takes effect
    idle(1'b1, 1);
    line(1'b0, 4, 8'd10, 8'd20, 8'd30, {8'd30, 8'd20, 8'd30, 8'd20});
    line(1'b1, 4, 8'd10, 8'd20, 8'd30, {8'd20, 8'd10, 8'd20, 8'd10});
    idle(1'b0, 3);

    // Frame D: gray bypass, single-pixel lines, enable change mid-frame
    mosaic_en = 1'b0;
    idle(1'b1, 1);
    line(1'b0, 1, 8'd255, 8'd255, 8'd255, {8'd255, 24'd0});
    line(1'b1, 1, 8'd4, 8'd8, 8'd0, {8'd5, 24'd0});
    mosaic_en = 1'b1;
    line(1'b0, 2, 8'd4, 8'd8, 8'd0, {8'd5, 8'd5, 16'd0});
    idle(1'b0, 3);

    // Frame E: GRBG, de gap inside one href splits it into two lines
    cfg_pattern = 2'd0;
    idle(1'b1, 1);
    for (int c = 0; c < 3; c++)
      pix(1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 8'd30, {1'b0, c[0]}, (c == 1) ? 8'd10 : 8'd20);
    repeat (2) pix(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'b00, 8'd0);
    for (int c = 0; c < 3; c++)
      pix(1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 8'd30, {1'b1, c[0]}, (c == 1) ? 8'd20 : 8'd30);
    idle(1'b1, 1);
    line(1'b0, 2, 8'd10, 8'd20, 8'd30, {8'd20, 8'd10, 16'd0});
    idle(1'b0, 3);

    // Frame F: GBRG latched, reset pulse mid-line
    cfg_pattern = 2'd3;
    idle(1'b1, 1);
    pix(1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 2'b00, 8'd20);
    pix(1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 2'b01, 8'd30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    per_img_href = 1'b0;
    per_img_de = 1'b0;
    #1;
    check("reset_midline_outputs",
          int'({post_img_vsync, post_img_href, post_img_de, post_img_raw, post_img_phase}), 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // vsync still high: no frame start seen, so reset config (GRBG pattern,
    // mosaic disabled -> gray) applies; gray(100,20,30) = 170>>2 = 42, row 0.
    line(1'b0, 2, 8'd100, 8'd20, 8'd30, {8'd42, 8'd42, 16'd0});
    idle(1'b0, 3);

    // Frame G: GRBG flat colour for loop-back reconstruction
    mosaic_en = 1'b1;
    cfg_pattern = 2'd0;
    cap_en = 1'b1;
    idle(1'b1, 1);
    for (int r = 0; r < 4; r++)
      line(r[0], 4, 8'd40, 8'd80, 8'd120,
           r[0] ? {8'd120, 8'd80, 8'd120, 8'd80} : {8'd80, 8'd40, 8'd80, 8'd40});
    idle(1'b0, 4);
    cap_en = 1'b0;
    check("loopback_capture_count", cap_n, 16);

    // Bilinear-style demosaic of interior pixels: average same-colour sites
    // in the 3x3 neighbourhood.
    for (int r = 1; r < 3; r++) begin
      for (int c = 1; c < 3; c++) begin
        for (int ch = 0; ch < 3; ch++) begin
          sum = 0;
          cnt = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (grbg_chan(r + dr, c + dc) == ch) begin
                sum += int'(cap[(r + dr) * 4 + (c + dc)]);
                cnt++;
              end
          req = (ch == 0) ? 40 : ((ch == 1) ? 80 : 120);
          check($sformatf("loopback_r%0dc%0d_ch%0d", r, c, ch), (cnt > 0) ? sum / cnt : -1, req);
        end
      end
    end

    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
